// File: rtl/load_store_unit.sv
// Load/store unit: maps CPU byte/half/word requests onto a word-wide data memory
// with a one-cycle registered read. Optional bounds check via LSU_BOUNDS_CHECK_EN.
module load_store_unit #(
  parameter int unsigned addresswidth = 32,
  parameter int unsigned depth        = 2**14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [addresswidth-1:0] req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    resp_valid,
  output logic [31:0]             resp_data,
  output logic                    resp_err,
  output logic [addresswidth-1:0] mem_address,
  output logic                    mem_read_en,
  output logic                    mem_write_en,
  output logic [31:0]             mem_data_in,
  input  logic [31:0]             mem_data_out
);

  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} state_t;

  state_t                  state, state_next;
  logic [1:0]              size_q;
  logic [1:0]              lane_q;
  logic                    signed_q;
  logic                    write_q;
  logic [DW-1:0]           wdata_q;
  logic                    accept_c;
  logic                    err_c;
  logic                    oob_c;
  logic [addresswidth-1:0] word_addr_c;
  logic [7:0]              byte_c;
  logic [15:0]             half_c;
  logic [DW-1:0]           load_c;
  logic [DW-1:0]           merge_c;

  if (depth == 0) begin : g_depth_chk
    $error("load_store_unit: depth must be nonzero");
  end

  assign req_ready   = (state == IDLE) && !reset;
  assign accept_c    = req_valid && req_ready;
  assign word_addr_c = {2'b00, req_addr[addresswidth-1:2]};

`ifdef LSU_BOUNDS_CHECK_EN
  assign oob_c = (word_addr_c >= addresswidth'(depth));
`else
  assign oob_c = 1'b0;
`endif

  // Misaligned, reserved-size and out-of-range requests never touch memory.
  assign err_c = (req_size == 2'b11)
              || ((req_size == 2'b01) && req_addr[0])
              || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
              || oob_c;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Strobes are decoded from state and gated by reset so a reset abandons any access.
  always_comb begin
    state_next   = state;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (err_c)                               state_next = RESP;
          else if (req_write && req_size == 2'b10) state_next = WR_ISSUE;
          else                                     state_next = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        mem_read_en = !reset;
        state_next  = RD_WAIT;
      end
      RD_WAIT:  state_next = write_q ? WR_ISSUE : RESP;
      WR_ISSUE: begin
        mem_write_en = !reset;
        state_next   = RESP;
      end
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    byte_c  = mem_data_out[{lane_q, 3'b000} +: 8];
    half_c  = mem_data_out[{lane_q[1], 4'b0000} +: 16];
    load_c  = mem_data_out;
    merge_c = mem_data_out;
    case (size_q)
      2'b00: begin
        load_c = signed_q ? {{24{byte_c[7]}}, byte_c} : {24'b0, byte_c};
        merge_c[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_c = signed_q ? {{16{half_c[15]}}, half_c} : {16'b0, half_c};
        merge_c[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_data   <= '0;
      mem_address <= '0;
      mem_data_in <= '0;
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      signed_q    <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
    end else begin
      resp_valid  <= (state_next == RESP);
      mem_data_in <= '0;
      if (accept_c) begin
        size_q    <= req_size;
        lane_q    <= req_addr[1:0];
        signed_q  <= req_signed;
        write_q   <= req_write;
        wdata_q   <= req_wdata;
        resp_err  <= err_c;
        resp_data <= '0;
        if (!err_c) mem_address <= word_addr_c;
        if (state_next == WR_ISSUE) mem_data_in <= req_wdata;
      end
      if (state == RD_WAIT) begin
        if (write_q) mem_data_in <= merge_c;
        else         resp_data   <= load_c;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, small word
// memory with registered read, directed plus random requests and mid-RMW reset.
module tb_load_store_unit;

  localparam int unsigned AW = 32;
  localparam int unsigned NW = 16;
`ifdef LSU_BOUNDS_CHECK_EN
  localparam int unsigned DEPTH = 16;
`else
  localparam int unsigned DEPTH = 2**14;
`endif

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          lat;
    int          acc;
    int          rd_base;
    int          wr_base;
    int          both_base;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_waddr;
    int          widx;
    logic [31:0] exp_word;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic [AW-1:0] mem_address;
  logic          mem_read_en;
  logic          mem_write_en;
  logic [31:0]   mem_data_in;
  logic [31:0]   mem_data_out;

  logic [31:0] ram [NW];
  logic        bd_we = 1'b0;
  logic [3:0]  bd_idx = 4'd0;
  logic [31:0] bd_data = 32'd0;
  int          cyc = 0;
  int          rd_total = 0;
  int          wr_total = 0;
  int          both_total = 0;
  logic [31:0] last_addr = 32'd0;

  logic [7:0]  mbytes [NW*4];
  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  load_store_unit #(.addresswidth(AW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .mem_address(mem_address), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial forever #5 clk = ~clk;

  // Data memory: registered read, garbage on the bus when not reading.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bd_we) ram[bd_idx] <= bd_data;
    else if (mem_write_en) ram[mem_address[3:0]] <= mem_data_in;
    mem_data_out <= mem_read_en ? ram[mem_address[3:0]] : 32'hA5A5_5A5A;
    if (mem_read_en) rd_total <= rd_total + 1;
    if (mem_write_en) wr_total <= wr_total + 1;
    if (mem_read_en && mem_write_en) both_total <= both_total + 1;
    if (mem_read_en || mem_write_en) last_addr <= mem_address;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_word(input int idx);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = mbytes[4*idx + i];
    return v;
  endfunction

  // Monitor: pops the scoreboard whenever a response appears.
  initial forever begin
    @(negedge clk);
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_data", resp_data, e.data);
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        chk("read_pulses", 32'(rd_total - e.rd_base), 32'(e.exp_rd));
        chk("write_pulses", 32'(wr_total - e.wr_base), 32'(e.exp_wr));
        chk("both_strobes", 32'(both_total - e.both_base), 32'd0);
        if (e.exp_rd + e.exp_wr > 0) chk("mem_address", last_addr, e.exp_waddr);
        chk("mem_word", ram[e.widx], e.exp_word);
      end
    end
  end

  task automatic bd_write(input int idx, input logic [31:0] val);
    @(negedge clk);
    bd_we = 1'b1;
    bd_idx = 4'(idx);
    bd_data = val;
    for (int i = 0; i < 4; i++) mbytes[4*idx + i] = val[8*i +: 8];
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic wait_ready(output logic ok);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (req_ready === 1'b1);
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic scramble_inputs();
    req_write  = 1'($urandom_range(0, 1));
    req_size   = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom_range(0, 1));
    req_addr   = AW'($urandom);
    req_wdata  = $urandom;
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = AW'(a);
    req_wdata  = wd;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    logic ok;
    int   nb;
    int   n;
    logic [31:0] v;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) return;
    drive(w, sz, sg, a, wd);
    nb = 1 << sz;
    e.err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`ifdef LSU_BOUNDS_CHECK_EN
    if ((a >> 2) >= DEPTH) e.err = 1'b1;
`endif
    e.acc = cyc;
    e.rd_base = rd_total;
    e.wr_base = wr_total;
    e.both_base = both_total;
    e.exp_waddr = a >> 2;
    e.widx = int'(a[5:2]);
    e.data = 32'd0;
    if (e.err) begin
      e.lat = 1; e.exp_rd = 0; e.exp_wr = 0;
    end else if (w) begin
      for (int i = 0; i < nb; i++) mbytes[int'(a) + i] = wd[8*i +: 8];
      e.lat = (sz == 2'd2) ? 2 : 4;
      e.exp_rd = (sz == 2'd2) ? 0 : 1;
      e.exp_wr = 1;
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mbytes[int'(a) + i];
      if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      e.data = v;
      e.lat = 3; e.exp_rd = 1; e.exp_wr = 0;
    end
    e.exp_word = model_word(e.widx);
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    scramble_inputs();
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  // Byte store to addr 1, reset asserted k negedges after the accept edge.
  task automatic reset_mid(input int k);
    logic ok;
    int   wr_base;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) return;
    drive(1'b1, 2'd0, 1'b0, 32'h1, 32'h0000_00C3);
    wr_base = wr_total;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("rst_read_en_gated", 32'(mem_read_en), 32'd0);
    chk("rst_write_en_gated", 32'(mem_write_en), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("rmw_abandoned_writes", 32'(wr_total - wr_base), 32'd0);
    chk("rmw_abandoned_word0", ram[0], model_word(0));
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    scramble_inputs();
    for (int i = 0; i < NW*4; i++) mbytes[i] = 8'd0;
    for (int i = 0; i < NW; i++) bd_write(i, $urandom);
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_err", 32'(resp_err), 32'd0);
    chk("reset_resp_data", resp_data, 32'd0);
    chk("reset_mem_address", mem_address, 32'd0);
    chk("reset_strobes", 32'({mem_read_en, mem_write_en}), 32'd0);
    reset = 1'b0;

    bd_write(0, 32'h8899_AABB);
    issue(1'b0, 2'd0, 1'b1, 32'h2, 32'd0);
    issue(1'b0, 2'd1, 1'b0, 32'h2, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'd0);
    issue(1'b1, 2'd0, 1'b0, 32'h1, 32'h0000_005A);
    chk("rmw_word0", ram[0], 32'h8899_5ABB);
    issue(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF);
    chk("word_store", ram[2], 32'hDEAD_BEEF);
    issue(1'b0, 2'd1, 1'b0, 32'h3, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h6, 32'd0);
    issue(1'b1, 2'd3, 1'b0, 32'h4, 32'h1234_5678);
    issue(1'b1, 2'd1, 1'b0, 32'hE, 32'hCAFE_F00D);
    issue(1'b0, 2'd1, 1'b1, 32'hE, 32'd0);

    reset_mid(2);
    reset_mid(1);

`ifdef LSU_BOUNDS_CHECK_EN
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
`endif

    for (int t = 0; t < 200; t++) begin
      logic        w;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] a;
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, NW*4 - 1));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      issue(w, sz, sg, a, $urandom);
    end

    for (int i = 0; i < 5; i++) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
